writeback_register_file: RTL and testbench

WRITEBACK_REGISTER_FILE -- requirements
Module: writeback_register_file

---
 rtl/writeback_register_file_if.sv | 30 +++
 rtl/writeback_register_file.sv | 103 ++++++++++
 tb/tb_writeback_register_file.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_register_file_if
// Brief    : Bundle of write-back / read-port signals for the register file.
//            The master drives the write-back and read addresses. The slave
//            (the register file) returns read data, Ready and WriteCount.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_register_file_if;
    logic        RegWriteIn;
    logic [31:0] WriteRegisterIn;
    logic [31:0] ALUResultIn;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Ready;
    logic [15:0] WriteCount;

    modport master (
        output RegWriteIn, WriteRegisterIn, ALUResultIn, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, Ready, WriteCount
    );

    modport slave (
        input  RegWriteIn, WriteRegisterIn, ALUResultIn, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, Ready, WriteCount
    );
endinterface
`default_nettype wire

// File: rtl/writeback_register_file.sv
`default_nettype none
// ============================================================================
// Module   : writeback_register_file
// Brief    : 32x32 register file with two combinational read ports and one
//            write-back port. Reads bypass (write-through) a write that is
//            accepted in the same cycle. After reset the block sweeps zeros
//            into every entry before it accepts writes. It also keeps a
//            saturating count of accepted writes.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_register_file (
    input  wire logic                Clock,
    input  wire logic                Reset,
    writeback_register_file_if.slave bus
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [4:0]  C_LAST_ENTRY = 5'd31;
    localparam logic [15:0] C_COUNT_MAX  = 16'hFFFF;

    state_t      r_state;
    logic [4:0]  r_sweep_cnt;
    logic        r_ready;
    logic [15:0] r_write_count;
    logic [31:0] r_mem [32];

    logic [4:0]  w_wr_idx;
    logic        w_wr_accept;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_unused;

    // Only the low five address bits select an entry. The upper bits are
    // deliberately ignored.
    assign w_wr_idx = bus.WriteRegisterIn[4:0];
    assign w_unused = &{1'b0, bus.WriteRegisterIn[31:5]};

    // A write counts only once the sweep is done. Writes to entry 0 and writes
    // in a reset cycle are dropped.
    assign w_wr_accept = (r_state == ST_READY) && !Reset && bus.RegWriteIn
                         && (w_wr_idx != 5'd0);

    // Control FSM: the sweep counter, the Ready flag and the saturating write counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= ST_INIT;
            r_sweep_cnt   <= 5'd0;
            r_ready       <= 1'b0;
            r_write_count <= 16'd0;
        end else if (r_state == ST_INIT) begin
            r_sweep_cnt <= r_sweep_cnt + 5'd1;
            if (r_sweep_cnt == C_LAST_ENTRY) begin
                r_state <= ST_READY;
                r_ready <= 1'b1;
            end
        end else begin
            if (w_wr_accept && (r_write_count != C_COUNT_MAX)) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    // Storage: the sweep writes zeros in INIT; accepted writes land in READY.
    // Reset does not clear the array; the sweep clears it.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_sweep_cnt] <= 32'd0;
            end else if (w_wr_accept) begin
                r_mem[w_wr_idx] <= bus.ALUResultIn;
            end
        end
    end

    // Read ports: zero during the sweep, write-through bypass, entry 0 hardwired to 0
    always_comb begin
        w_rd1 = 32'd0;
        w_rd2 = 32'd0;
        if (r_state == ST_READY) begin
            if (w_wr_accept && (bus.ReadRegister1 == w_wr_idx)) begin
                w_rd1 = bus.ALUResultIn;
            end else if (bus.ReadRegister1 != 5'd0) begin
                w_rd1 = r_mem[bus.ReadRegister1];
            end
            if (w_wr_accept && (bus.ReadRegister2 == w_wr_idx)) begin
                w_rd2 = bus.ALUResultIn;
            end else if (bus.ReadRegister2 != 5'd0) begin
                w_rd2 = r_mem[bus.ReadRegister2];
            end
        end
    end

    assign bus.ReadData1  = w_rd1;
    assign bus.ReadData2  = w_rd2;
    assign bus.Ready      = r_ready;
    assign bus.WriteCount = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_register_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_writeback_register_file
// Brief    : Self-checking bench for writeback_register_file. It covers the
//            sweep, a vector table, reset corners, random traffic against a
//            reference model, and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_register_file_if bus();

    writeback_register_file dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // The model tracks non-reset edges since the last reset. After 32 such
    // edges the block is ready, and every entry holds zero until it is written.
    logic [31:0] m_mem [32];
    int          m_edges = 0;
    int          m_cnt   = 0;

    function automatic bit m_ready();
        return (m_edges >= 32);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] ra);
        if (!m_ready()) return 32'd0;
        if (!rst && bus.RegWriteIn && (bus.WriteRegisterIn[4:0] != 5'd0)
            && (ra == bus.WriteRegisterIn[4:0])) return bus.ALUResultIn;
        if (ra == 5'd0) return 32'd0;
        return m_mem[ra];
    endfunction

    task automatic m_step();
        if (rst) begin
            m_edges = 0;
            m_cnt   = 0;
        end else if (!m_ready()) begin
            m_edges++;
            if (m_edges == 32) begin
                for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            end
        end else if (bus.RegWriteIn && (bus.WriteRegisterIn[4:0] != 5'd0)) begin
            m_mem[bus.WriteRegisterIn[4:0]] = bus.ALUResultIn;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(bit r, bit we, logic [31:0] wa, logic [31:0] d,
                          logic [4:0] r1, logic [4:0] r2);
        rst                 = r;
        bus.RegWriteIn      = we;
        bus.WriteRegisterIn = wa;
        bus.ALUResultIn     = d;
        bus.ReadRegister1   = r1;
        bus.ReadRegister2   = r2;
    endtask

    task automatic advance();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, " rd1"},   bus.ReadData1, m_read(bus.ReadRegister1));
        chk({tag, " rd2"},   bus.ReadData2, m_read(bus.ReadRegister2));
        chk({tag, " ready"}, {31'd0, bus.Ready}, {31'd0, m_ready()});
        chk({tag, " count"}, {16'd0, bus.WriteCount}, m_cnt[31:0]);
    endtask

    // Reset for one cycle, then run the sweep while checking Ready on each edge
    task automatic reset_and_sweep(string tag);
        set_in(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        advance();
        chk({tag, " post-reset ready"}, {31'd0, bus.Ready}, 32'd0);
        chk({tag, " post-reset count"}, {16'd0, bus.WriteCount}, 32'd0);
        chk({tag, " post-reset rd1"}, bus.ReadData1, 32'd0);
        chk({tag, " post-reset rd2"}, bus.ReadData2, 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int k = 1; k <= 32; k++) begin
            advance();
            if (k == 31 || k == 32)
                chk($sformatf("%s sweep ready edge %0d", tag, k),
                    {31'd0, bus.Ready}, (k == 32) ? 32'd1 : 32'd0);
            else if (bus.Ready !== 1'b0)
                chk($sformatf("%s sweep early ready edge %0d", tag, k),
                    {31'd0, bus.Ready}, 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [31:0] data;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tv [10];

    initial begin
        int edges;
        bit seen;
        logic [31:0] v;

        tv[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0,        16'd0};
        tv[1] = '{1'b0, 32'd0,          32'd0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        tv[2] = '{1'b1, 32'd7,          32'h12345678, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 16'd1};
        tv[3] = '{1'b1, 32'd0,          32'hFFFFFFFF, 5'd0, 5'd7, 32'd0,        32'h12345678, 16'd2};
        tv[4] = '{1'b1, 32'h00000020,   32'h00000001, 5'd0, 5'd5, 32'd0,        32'hDEADBEEF, 16'd2};
        tv[5] = '{1'b0, 32'd0,          32'd0,        5'd0, 5'd0, 32'd0,        32'd0,        16'd2};
        tv[6] = '{1'b1, 32'hFFFFFFE3,   32'h0000A5A5, 5'd3, 5'd4, 32'h0000A5A5, 32'd0,        16'd2};
        tv[7] = '{1'b0, 32'd0,          32'd0,        5'd3, 5'd7, 32'h0000A5A5, 32'h12345678, 16'd3};
        tv[8] = '{1'b1, 32'd5,          32'h00000001, 5'd5, 5'd5, 32'h00000001, 32'h00000001, 16'd3};
        tv[9] = '{1'b0, 32'd0,          32'd0,        5'd5, 5'd3, 32'h00000001, 32'h0000A5A5, 16'd4};

        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        set_in(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;

        // First sweep, then fill every entry with nonzero data
        reset_and_sweep("init");
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 1'b1, i, 32'hA0000000 | i, 5'd0, 5'd0);
            advance();
        end
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd17, 5'd31);
        #1;
        chk("prefill rd1", bus.ReadData1, 32'hA0000011);
        chk("prefill rd2", bus.ReadData2, 32'hA000001F);

        // Sweep over a filled array; every entry must read back as zero
        reset_and_sweep("refill");
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 1'b0, 32'd0, 32'd0, i, 31 - i);
            #1;
            chk($sformatf("swept rd1[%0d]", i), bus.ReadData1, 32'd0);
            chk($sformatf("swept rd2[%0d]", 31 - i), bus.ReadData2, 32'd0);
        end

        // Table-driven vectors starting from a fresh, cleared READY state
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, tv[i].we, tv[i].wa, tv[i].data, tv[i].r1, tv[i].r2);
            @(negedge clk);
            chk($sformatf("vec%0d rd1", i), bus.ReadData1, tv[i].e1);
            chk($sformatf("vec%0d rd2", i), bus.ReadData2, tv[i].e2);
            chk($sformatf("vec%0d count", i), {16'd0, bus.WriteCount}, {16'd0, tv[i].ecnt});
            advance();
        end

        // Reset in READY together with a write: the write is dropped and the count clears
        set_in(1'b1, 1'b1, 32'd9, 32'h55555555, 5'd9, 5'd0);
        advance();
        chk("ready-reset count", {16'd0, bus.WriteCount}, 32'd0);
        chk("ready-reset ready", {31'd0, bus.Ready}, 32'd0);

        // Mid-sweep reset at edge 10; writes during the sweep must be ignored
        set_in(1'b0, 1'b1, 32'd9, 32'h77777777, 5'd9, 5'd9);
        for (int k = 1; k <= 9; k++) advance();
        chk("mid-sweep rd1 zero", bus.ReadData1, 32'd0);
        set_in(1'b1, 1'b1, 32'd9, 32'h77777777, 5'd9, 5'd9);
        advance();
        set_in(1'b0, 1'b1, 32'd9, 32'h77777777, 5'd9, 5'd9);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(negedge clk);
            if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0)
                chk("init read zero", bus.ReadData1 | bus.ReadData2, 32'd0);
            set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd9, 5'd9);
            advance();
            set_in(1'b0, 1'b1, 32'd9, 32'h77777777, 5'd9, 5'd9);
            edges++;
            seen = bus.Ready;
        end
        chk("mid-sweep edges to ready", edges, 32'd32);
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        chk("init write ignored", bus.ReadData1, 32'd0);
        chk("init count held", {16'd0, bus.WriteCount}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v[31:5] = 27'd0;
            set_in(r, r ? 1'b0 : 1'($urandom_range(0, 1)), v, $urandom,
                   5'($urandom), ($urandom_range(0, 2) == 0) ? v[4:0] : 5'($urandom));
            @(negedge clk);
            check_model($sformatf("rand%0d", n));
            advance();
        end

        // Saturation of the write counter
        reset_and_sweep("sat");
        for (int i = 0; i < 65540; i++) begin
            set_in(1'b0, 1'b1, 1 + (i % 31), $urandom, 5'd1, 5'd2);
            advance();
            if (i == 65533) chk("sat count 65534", {16'd0, bus.WriteCount}, 32'h0000FFFE);
            if (i == 65534) chk("sat count 65535", {16'd0, bus.WriteCount}, 32'h0000FFFF);
        end
        chk("sat count after 65540", {16'd0, bus.WriteCount}, 32'h0000FFFF);
        set_in(1'b0, 1'b1, 32'd4, 32'h0BADF00D, 5'd4, 5'd1);
        @(negedge clk);
        check_model("sat final");
        advance();
        chk("sat count held", {16'd0, bus.WriteCount}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
